// File: rtl/serial_add_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module  : serial_add_scheduler_if
// Brief   : Requester, stall and result handshake bundle for the serial adder.
// Revision: 1.0
// ============================================================================
interface serial_add_scheduler_if #(
    parameter int W = 8
);
    logic         req0_vld;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_rdy;

    logic         req1_vld;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_rdy;

    logic         stall;

    logic         res_vld;
    logic [W-1:0] res_sum;
    logic         res_cout;
    logic         res_id;
    logic         res_rdy;

    modport master (
        output req0_vld, req0_a, req0_b,
        output req1_vld, req1_a, req1_b,
        output stall, res_rdy,
        input  req0_rdy, req1_rdy,
        input  res_vld, res_sum, res_cout, res_id
    );

    modport slave (
        input  req0_vld, req0_a, req0_b,
        input  req1_vld, req1_a, req1_b,
        input  stall, res_rdy,
        output req0_rdy, req1_rdy,
        output res_vld, res_sum, res_cout, res_id
    );
endinterface
`default_nettype wire

// File: rtl/serial_add_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : serial_add_scheduler
// Brief   : Two-requester round-robin front end feeding a bit-serial adder.
// Revision: 1.0
// ============================================================================
module serial_add_scheduler #(
    parameter int W = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    serial_add_scheduler_if.slave  bus
);
    localparam int              IW     = (W > 1) ? $clog2(W) : 1;
    localparam logic [IW-1:0]   C_LAST = IW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_next;

    logic           r_rst_meta;
    logic           r_run;

    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [W-1:0]   r_sum;
    logic [IW-1:0]  r_idx;
    logic           r_carry;
    logic           r_cout;
    logic           r_id;
    logic           r_last;

    logic           w_gnt0;
    logic           w_gnt1;
    logic           w_rdy0;
    logic           w_rdy1;
    logic           w_accept;
    logic           w_step;
    logic           w_abit;
    logic           w_bbit;
    logic           w_sbit;
    logic           w_cnext;

    // Two-flop release synchroniser; r_run gates every grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rst_meta <= 1'b0;
            r_run      <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_run      <= r_rst_meta;
        end
    end

    // On a tie the requester that was not served last wins.
    assign w_gnt0   = bus.req0_vld & (~bus.req1_vld | r_last);
    assign w_gnt1   = bus.req1_vld & (~bus.req0_vld | ~r_last);
    assign w_rdy0   = (r_state == S_IDLE) & r_run & w_gnt0;
    assign w_rdy1   = (r_state == S_IDLE) & r_run & w_gnt1;
    assign w_accept = w_rdy0 | w_rdy1;

    assign w_step   = (r_state == S_SHIFT) & ~bus.stall;
    assign w_abit   = r_a[r_idx];
    assign w_bbit   = r_b[r_idx];
    assign w_sbit   = w_abit ^ w_bbit ^ r_carry;
    assign w_cnext  = (w_abit & w_bbit) | (r_carry & (w_abit ^ w_bbit));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_SHIFT;
            S_SHIFT: if (w_step && (r_idx == C_LAST)) w_next = S_DONE;
            S_DONE:  if (bus.res_rdy) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_id    <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            if (w_accept) begin
                r_a     <= w_rdy1 ? bus.req1_a : bus.req0_a;
                r_b     <= w_rdy1 ? bus.req1_b : bus.req0_b;
                r_id    <= w_rdy1;
                r_last  <= w_rdy1;
                r_carry <= 1'b0;
                r_idx   <= '0;
            end
            if (w_step) begin
                r_sum[r_idx] <= w_sbit;
                r_carry      <= w_cnext;
                if (r_idx == C_LAST) begin
                    r_cout <= w_cnext;
                end else begin
                    r_idx  <= r_idx + IW'(1);
                end
            end
        end
    end

    assign bus.req0_rdy = w_rdy0;
    assign bus.req1_rdy = w_rdy1;
    assign bus.res_vld  = (r_state == S_DONE);
    assign bus.res_sum  = r_sum;
    assign bus.res_cout = r_cout;
    assign bus.res_id   = r_id;
endmodule
`default_nettype wire

// File: tb/tb_serial_add_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_add_scheduler
// Brief   : Scoreboard bench for serial_add_scheduler (W = 8).
// Revision: 1.0
// ============================================================================
module tb_serial_add_scheduler;
    localparam int W = 8;

    typedef struct packed {
        logic         id;
        logic [W-1:0] sum;
        logic         cout;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc_cnt  = 0;
    logic m_last;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    serial_add_scheduler_if #(.W(W)) bus ();
    serial_add_scheduler #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    function automatic exp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] full;
        full = {1'b0, a} + {1'b0, b};
        return '{id: id, sum: full[W-1:0], cout: full[W]};
    endfunction

    function automatic exp_t observed();
        return '{id: bus.res_id, sum: bus.res_sum, cout: bus.res_cout};
    endfunction

    // Raise one request and wait (bounded) for its grant; returns at accept edge + 1.
    task automatic do_accept(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                             output bit ok);
        ok = 1'b0;
        if (id) begin bus.req1_a = a; bus.req1_b = b; bus.req1_vld = 1'b1; end
        else    begin bus.req0_a = a; bus.req0_b = b; bus.req0_vld = 1'b1; end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (id ? bus.req1_rdy : bus.req0_rdy) begin
                sb.push_back(model(id, a, b));
                m_last = id;
                ok     = 1'b1;
                @(posedge clk); #1;
                break;
            end
        end
        bus.req0_vld = 1'b0;
        bus.req1_vld = 1'b0;
        bus.req0_a   = 8'hEE;
        bus.req0_b   = 8'hEE;
        bus.req1_a   = 8'hDD;
        bus.req1_b   = 8'hDD;
    endtask

    // Counts edges from acceptance until res_vld; bit k of smask stalls edge k+1.
    task automatic wait_result(input logic [31:0] smask, output int cyc);
        cyc = 0;
        while (!bus.res_vld && cyc < 64) begin
            bus.stall = (cyc < 32) ? smask[cyc] : 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        bus.stall = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.req0_vld = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (observed() !== '0 || bus.res_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got vld=%b res=%h required vld=0 res=0", bus.res_vld, observed());
        end
        n_checks++;
        if (bus.req0_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rdy: got %b required 0", bus.req0_rdy);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.req0_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_sync: got rdy0=%b required 0 before first edge", bus.req0_rdy);
        end
        bus.req0_vld = 1'b0;
        m_last = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        bit   ok;
        int   cyc;
        exp_t e;
        do_accept(1'b0, 8'h5A, 8'h33, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL basic_accept: got no grant required grant"); end
        wait_result(32'h0, cyc);
        n_checks++;
        if (cyc != W) begin n_fail++; $display("FAIL basic_latency: got %0d required %0d", cyc, W); end
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        n_checks++;
        if (observed() !== e || e !== exp_t'({1'b0, 8'h8D, 1'b0})) begin
            n_fail++;
            $display("FAIL basic_result: got %h required %h", observed(), e);
        end
        @(posedge clk); #1;
        n_checks++;
        if (bus.res_vld !== 1'b0) begin n_fail++; $display("FAIL basic_consume: got vld=%b required 0", bus.res_vld); end
    endtask

    task automatic test_carry();
        bit   ok;
        int   cyc;
        exp_t e;
        logic [W-1:0] av [2] = '{8'hFF, 8'h00};
        logic [W-1:0] bv [2] = '{8'h01, 8'h00};
        for (int k = 0; k < 2; k++) begin
            do_accept(1'b0, av[k], bv[k], ok);
            wait_result(32'h0, cyc);
            e = (sb.size() > 0) ? sb.pop_front() : '0;
            n_checks++;
            if (!ok || cyc != W || observed() !== e) begin
                n_fail++;
                $display("FAIL carry_op%0d: got %h cyc=%0d required %h cyc=%0d", k, observed(), cyc, e, W);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_round_robin();
        int   cyc;
        int   t_prev;
        logic win;
        bit   got;
        exp_t e;
        t_prev = -1;
        bus.req0_a = 8'h10; bus.req0_b = 8'h01; bus.req0_vld = 1'b1;
        bus.req1_a = 8'h20; bus.req1_b = 8'h02; bus.req1_vld = 1'b1;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int i = 0; i < 30 && !got; i++) begin
                @(negedge clk);
                got = bus.req0_rdy | bus.req1_rdy;
            end
            win = ~m_last;
            n_checks++;
            if ({bus.req1_rdy, bus.req0_rdy} !== (win ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL rr_grant%0d: got rdy=%b%b required winner %0d", k, bus.req1_rdy, bus.req0_rdy, win);
            end
            sb.push_back(win ? model(1'b1, 8'h20, 8'h02) : model(1'b0, 8'h10, 8'h01));
            m_last = win;
            if (t_prev >= 0) begin
                n_checks++;
                if (cyc_cnt - t_prev != W + 2) begin
                    n_fail++;
                    $display("FAIL rr_interval%0d: got %0d required %0d", k, cyc_cnt - t_prev, W + 2);
                end
            end
            t_prev = cyc_cnt;
            @(posedge clk); #1;
            wait_result(32'h0, cyc);
            if (k == 3) begin bus.req0_vld = 1'b0; bus.req1_vld = 1'b0; end
            e = (sb.size() > 0) ? sb.pop_front() : '0;
            n_checks++;
            if (cyc != W || observed() !== e) begin
                n_fail++;
                $display("FAIL rr_result%0d: got %h cyc=%0d required %h cyc=%0d", k, observed(), cyc, e, W);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        bit   ok;
        int   cyc;
        exp_t e;
        do_accept(1'b1, 8'hC3, 8'h7E, ok);
        wait_result(32'h0000_041C, cyc);
        n_checks++;
        if (!ok || cyc != W + 4) begin n_fail++; $display("FAIL stall_latency: got %0d required %0d", cyc, W + 4); end
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        n_checks++;
        if (observed() !== e) begin n_fail++; $display("FAIL stall_result: got %h required %h", observed(), e); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        bit   ok;
        int   cyc;
        exp_t e;
        exp_t snap;
        bus.res_rdy = 1'b0;
        do_accept(1'b0, 8'h9C, 8'h87, ok);
        wait_result(32'h0, cyc);
        e    = (sb.size() > 0) ? sb.pop_front() : '0;
        snap = observed();
        n_checks++;
        if (!ok || cyc != W || snap !== e) begin
            n_fail++;
            $display("FAIL bp_result: got %h cyc=%0d required %h cyc=%0d", snap, cyc, e, W);
        end
        bus.req1_a = 8'h44; bus.req1_b = 8'h55; bus.req1_vld = 1'b1;
        bus.stall  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus.res_vld !== 1'b1 || observed() !== snap || bus.req0_rdy !== 1'b0 || bus.req1_rdy !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got vld=%b res=%h rdy=%b%b required vld=1 res=%h rdy=00",
                         i, bus.res_vld, observed(), bus.req1_rdy, bus.req0_rdy, snap);
            end
        end
        bus.stall   = 1'b0;
        bus.res_rdy = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bus.res_vld !== 1'b0 || bus.req1_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: got vld=%b rdy1=%b required vld=0 rdy1=1", bus.res_vld, bus.req1_rdy);
        end
        sb.push_back(model(1'b1, 8'h44, 8'h55));
        m_last = 1'b1;
        @(posedge clk); #1;
        bus.req1_vld = 1'b0;
        wait_result(32'h0, cyc);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        n_checks++;
        if (cyc != W || observed() !== e) begin
            n_fail++;
            $display("FAIL bp_next: got %h cyc=%0d required %h cyc=%0d", observed(), cyc, e, W);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midop();
        bit   ok;
        bit   seen;
        int   cyc;
        exp_t e;
        do_accept(1'b1, 8'h0F, 8'h00, ok);
        repeat (4) @(posedge clk);
        #2;
        bus.req0_vld = 1'b1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.res_vld !== 1'b0 || observed() !== '0 || bus.req0_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_reset: got vld=%b res=%h rdy0=%b required all 0", bus.res_vld, observed(), bus.req0_rdy);
        end
        if (sb.size() > 0) void'(sb.pop_back());
        bus.req0_vld = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.res_vld) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL midop_ghost: got res_vld=1 required none"); end
        bus.req0_a = 8'h01; bus.req0_b = 8'h02; bus.req0_vld = 1'b1;
        bus.req1_a = 8'h03; bus.req1_b = 8'h04; bus.req1_vld = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            ok = bus.req0_rdy | bus.req1_rdy;
        end
        n_checks++;
        if ({bus.req1_rdy, bus.req0_rdy} !== 2'b01) begin
            n_fail++;
            $display("FAIL midop_tie: got rdy=%b%b required 01", bus.req1_rdy, bus.req0_rdy);
        end
        sb.push_back(model(1'b0, 8'h01, 8'h02));
        m_last = 1'b0;
        @(posedge clk); #1;
        bus.req0_vld = 1'b0;
        bus.req1_vld = 1'b0;
        wait_result(32'h0, cyc);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        n_checks++;
        if (cyc != W || observed() !== e) begin
            n_fail++;
            $display("FAIL midop_after: got %h cyc=%0d required %h cyc=%0d", observed(), cyc, e, W);
        end
        @(posedge clk); #1;
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL sb_empty: got %0d entries required 0", sb.size()); end
    endtask

    initial begin
        bus.req0_vld = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_vld = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
        bus.stall    = 1'b0;
        bus.res_rdy  = 1'b1;
        m_last       = 1'b1;
        test_reset();
        test_basic();
        test_carry();
        test_round_robin();
        test_stall();
        test_backpressure();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
